// File: rtl/mixcol_seq_if.sv
// Handshake bundle for mixcol_seq: input state offer, result return and busy status.
// The DUT takes the slave modport; the producer/consumer side takes master.
interface mixcol_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         inv;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, inv, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, inv, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/mixcol_seq.sv
// AES (Inv)MixColumns over a 128-bit state with one shared GF(2^8) multiplier, one product per clock.
// Latency 64 clocks accept->out_valid; result held stable while out_ready is low, no accept until handshake.
module mixcol_seq #(
  parameter int SZ = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  mixcol_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [127:0]    st_q, st_d;
  logic [127:0]    out_q, out_d;
  logic            inv_q, inv_d;
  logic [5:0]      idx_q, idx_d;
  logic [SZ-1:0]   acc_q, acc_d;

  logic [1:0]      col, row, kk, csel;
  logic [SZ-1:0]   opnd, coef, prod;
  logic            accept;

  function automatic logic [SZ-1:0] gmul(input logic [SZ-1:0] a, input logic [SZ-1:0] b);
    logic [SZ-1:0] p;
    logic [SZ-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < SZ; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[SZ-2:0], 1'b0} ^ (x[SZ-1] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Index is {column, row, k} with k fastest.
  assign {col, row, kk} = idx_q;
  assign csel   = kk - row;
  assign accept = bus.in_valid && bus.in_ready;

  // Byte {col,k} counted from the MSB sits at bit offset 8*(15-{col,k}).
  assign opnd = st_q[{~{col, kk}, 3'b000} +: 8];
  assign prod = gmul(coef, opnd);

  always_comb begin
    coef = 8'h00;
    case ({inv_q, csel})
      3'b000: coef = 8'h02;
      3'b001: coef = 8'h03;
      3'b010: coef = 8'h01;
      3'b011: coef = 8'h01;
      3'b100: coef = 8'h0e;
      3'b101: coef = 8'h0b;
      3'b110: coef = 8'h0d;
      3'b111: coef = 8'h09;
      default: coef = 8'h00;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (idx_q == 6'd63) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && rst_n;
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.state_out = out_q;
  end

  always_comb begin
    st_d  = st_q;
    inv_d = inv_q;
    idx_d = idx_q;
    acc_d = acc_q;
    out_d = out_q;
    if (state_q == IDLE && accept) begin
      st_d  = bus.state_in;
      inv_d = bus.inv;
      idx_d = '0;
      acc_d = '0;
    end else if (state_q == RUN) begin
      // Natural 6-bit wrap returns the index to 0 exactly on the last product.
      idx_d = idx_q + 6'd1;
      if (kk == 2'd3) begin
        out_d[{~{col, row}, 3'b000} +: 8] = acc_q ^ prod;
        acc_d = '0;
      end else begin
        acc_d = acc_q ^ prod;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= '0;
      inv_q <= 1'b0;
      idx_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      st_q  <= st_d;
      inv_q <= inv_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

endmodule

// File: doc/mixcol_seq.md
# mixcol_seq

Sequencer that runs AES MixColumns or InvMixColumns over a full 128-bit state using one shared GF(2^8) multiplier (AES polynomial 0x11b, 8-bit operands). It computes one byte product per clock and XOR-accumulates the 16 products per column, so the area cost is a single multiplier instead of sixteen. It sits between the round-key/ShiftRows stage and the next round register in the encrypt/decrypt round datapath. Valid/ready handshakes on both sides.

## Interface
- sz, 8, GF element width; only 8 is supported (coefficients and the 0x11b polynomial are fixed)
- clk  in  1  rising-edge clock; one clock domain
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  state_in/inv offered
- in_ready  out  1  block can accept; high only in IDLE with rst_n high
- inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled only at accept
- state_in  in  128  input state; sampled only at accept
- out_valid  out  1  state_out holds a complete result
- out_ready  in  1  downstream accepts result
- state_out  out  128  result register
- busy  out  1  high in RUN and DONE

## Operation
- Byte map: column c = bits [127-32c -: 32]; row r within column = bits [31-8r -: 8]; byte s[r][c].
- Coefficients: base = {02,03,01,01} (forward) or {0e,0b,0d,09} (inverse, latched). M[r][k] = base[(k-r) mod 4].
- out[r][c] = XOR over k=0..3 of gmul(M[r][k], s[k][c]); gmul = GF(2^8) product mod 0x11b.
- FSM states IDLE, RUN, DONE.
- IDLE: in_ready=1. in_valid&in_ready at an edge: capture state_in and inv, clear 6-bit index {c,r,k} and the 8-bit accumulator, go to RUN.
- RUN: each clock, multiplier operands are s[k][c] (from the captured state) and M[r][k]; acc <= acc ^ product. When k=3, write acc^product into state_out byte [r][c] and clear acc. The index increments with k fastest, then r, then c. After index 63, go to DONE.
- DONE: out_valid=1. out_valid&out_ready at an edge: go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle bypass.
- Captured state and inv are held for the whole RUN. in_valid, state_in and inv are ignored outside IDLE.
- Multiplier path is combinational from the operand mux to the accumulator, with no internal pipeline stage.
- state_out keeps its last result after the handshake. It is valid only while out_valid=1, and bytes change during the next RUN.

## Timing
- Reset (rst_n low at an edge): state IDLE, index 0, acc 0, state_out 0, out_valid 0, busy 0. in_ready is forced 0 while rst_n is low.
- rst_n low during RUN or DONE discards the operation. The block is in IDLE with in_ready=1 the cycle after rst_n returns high.
- Latency: accept at edge E0; products at edges E1..E64; out_valid=1 from E64. That is 64 clocks from accept to valid.
- Throughput: the earliest next accept is the edge after the output handshake. With in_valid and out_ready held high, one block is processed every 66 clocks.
- Backpressure: while out_ready=0 in DONE, out_valid and state_out hold stable indefinitely.
- Index wrap 63 to 0 happens only on the RUN to DONE transition. The index is not reused across blocks without a fresh clear at accept.

## Test plan
- Forward: inv=0, state_in=db135345_f20a225c_01010101_c6c6c6c6 -> state_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid exactly 64 clocks after accept.
- Inverse: inv=1, state_in=8e4da1bc_9fdc589d_01010101_c6c6c6c6 -> db135345_f20a225c_01010101_c6c6c6c6. Also check inv=0 on column d4d4d4d5 -> d5d5d7d6.
- Capture isolation: after accept, toggle inv and drive state_in=ffff...ff throughout RUN -> result equals the forward vector above. in_valid asserted in RUN/DONE is not accepted (in_ready=0).
- Backpressure: hold out_ready=0 for 10 clocks in DONE -> out_valid=1 and state_out unchanged each clock, busy=1. Release -> IDLE next clock.
- Reset mid-run: drop rst_n at clock 30 of RUN -> out_valid=0, state_out=0, busy=0. Next block (all-zero state, inv=0) returns 0 after 64 clocks.
- Back-to-back: in_valid and out_ready held high with two vectors -> second accept on the edge after the first output handshake, results correct, 66-clock spacing between out_valid rises.
